alu_result_collector: RTL and testbench
=======================================

Name: alu_result_collector

Overview:
Downstream stage of the ALU. It consumes the ALU's DATA/VLD result beats and merges the two-beat multiply result (low word, then high word) into one 64-bit entry. Each completed result is tagged with its destination register and buffered in a small FIFO. Entries drain to the register-file write port over a valid/ready handshake, and the block gives the issue logic a credit signal so the ALU (which cannot stall) is never started without buffer space.

Parameters:
DEPTH, 4, result FIFO entries (power of two, >= 2)
DST_W, 5, destination register index width

Ports:
CLK  input  1  clock
RST  input  1  reset, synchronous, active-high
ISSUE  input  1  pulse: an op is being started on the ALU this cycle (ACT & RDY)
ISSUE_MUL  input  1  op being issued is a multiply (two result beats)
ISSUE_DST  input  DST_W  destination register of the issued op
ISSUE_OK  output  1  credit: an ISSUE this cycle is guaranteed buffer space
ALU_VLD  input  1  ALU result beat valid
ALU_DATA  input  32  ALU result beat
WB_VALID  output  1  head FIFO entry available
WB_READY  input  1  register file accepts head entry
WB_DST  output  DST_W  head entry destination
WB_LO  output  32  head entry low word
WB_HI  output  32  head entry high word (0 when WB_WIDE=0)
WB_WIDE  output  1  head entry is a 64-bit multiply result
BUSY  output  1  op outstanding or FIFO non-empty
ERR  output  1  sticky protocol-error flag

Behaviour:
- Reset: the state machine goes to IDLE, FIFO pointers/count clear, ERR=0. Outputs after reset: WB_VALID=0, WB_DST/LO/HI/WIDE=0, BUSY=0, ISSUE_OK=1.
- Reset mid-operation discards the outstanding tag, any captured low word and all FIFO entries. No partial entry survives.
- Collector FSM states: IDLE, WAIT_SINGLE, WAIT_LO, WAIT_HI.
  - IDLE + ISSUE & ISSUE_OK: capture ISSUE_DST and go to WAIT_LO if ISSUE_MUL, else WAIT_SINGLE.
  - WAIT_SINGLE + ALU_VLD: push {dst, lo=ALU_DATA, hi=0, wide=0}, go to IDLE.
  - WAIT_LO + ALU_VLD: capture lo=ALU_DATA, go to WAIT_HI.
  - WAIT_HI + ALU_VLD: push {dst, lo, hi=ALU_DATA, wide=1}, go to IDLE.
  - WAIT_HI without ALU_VLD: set ERR and go to IDLE. Multiply beats must be back-to-back.
- Credit rule: ISSUE_OK = (state==IDLE) & (count < DEPTH). The state is IDLE, so nothing is in flight. Because an entry is reserved at issue, a push always finds space.
- Protocol errors set ERR and are otherwise ignored:
  - ISSUE while ISSUE_OK=0;
  - ALU_VLD in IDLE;
  - a push while the FIFO is full (data dropped).
  ERR clears only on RST.
- FIFO: registered, no bypass. A pushed entry appears on WB_* the cycle after the final ALU beat.
- Pop when WB_VALID & WB_READY.
- Push and pop in the same cycle: count is unchanged and both happen. This is legal even when full, because the pop frees space first.
- Pointers wrap modulo DEPTH. When empty, WB_* hold 0 and WB_VALID=0.
- WB_* are stable while WB_VALID=1 and WB_READY=0.
- Latency from ISSUE to WB_VALID: 3 cycles for a non-mul op, 4 cycles for mul (ALU latency + 1).
- BUSY = (state != IDLE) | (count != 0).

Decomposition:
- Shared package alu_pkg: the collector state enum, and a wb_entry_t struct {dst, lo, hi, wide}.
- One sub-module, alu_result_fifo: a generic DEPTH-deep synchronous FIFO of wb_entry_t with push/pop/full/empty/count.
- The collector FSM, credit logic and ERR flag live in the top module.

Test Plan:
- Add op: ISSUE, DST=3, ISSUE_MUL=0; ALU_VLD with DATA=0x0000_0007 two cycles later -> WB_VALID=1 the next cycle with DST=3, LO=7, HI=0, WIDE=0. WB_READY=1 pops it and BUSY falls.
- Multiply: ISSUE, DST=9, MUL=1; beats 0xFFFF_FFFE then 0x0000_0001 -> one entry with LO=0xFFFF_FFFE, HI=1, WIDE=1. No WB_VALID between the two beats.
- Backpressure: WB_READY=0, four single ops issued -> ISSUE_OK=0 after the 4th is pushed. One pop raises ISSUE_OK the next cycle. Entries drain in issue order.
- Simultaneous push/pop with count=DEPTH-1 and WB_READY=1 -> count stays 3, no ERR, order preserved.
- Errors: ALU_VLD in IDLE -> ERR=1 and no entry pushed. Mul with a gap after the low beat -> ERR=1, state IDLE, no entry.
- Reset during WAIT_HI with 2 entries queued -> next cycle WB_VALID=0, BUSY=0, ISSUE_OK=1, ERR=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU result collector: collector FSM states and the
// write-back entry carried through the result FIFO.
package alu_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ENTRY_DST_W = 5;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_SINGLE = 2'd1,
    WAIT_LO     = 2'd2,
    WAIT_HI     = 2'd3
  } coll_state_e;

  typedef struct packed {
    logic [ENTRY_DST_W-1:0] dst;
    logic [DATA_W-1:0]      lo;
    logic [DATA_W-1:0]      hi;
    logic                   wide;
  } wb_entry_t;

  function automatic wb_entry_t mk_entry(input logic [ENTRY_DST_W-1:0] dst,
                                         input logic [DATA_W-1:0]      lo,
                                         input logic [DATA_W-1:0]      hi,
                                         input logic                   wide);
    wb_entry_t e;
    e.dst  = dst;
    e.lo   = lo;
    e.hi   = hi;
    e.wide = wide;
    return e;
  endfunction

endpackage

// File: rtl/alu_result_collector_if.sv
// Issue / ALU-beat / write-back signal bundle of the result collector.
// master = issue logic, ALU and register file; slave = the collector.
interface alu_result_collector_if #(
  parameter int unsigned DST_W = alu_pkg::ENTRY_DST_W
);

  logic                      ISSUE;
  logic                      ISSUE_MUL;
  logic [DST_W-1:0]          ISSUE_DST;
  logic                      ISSUE_OK;
  logic                      ALU_VLD;
  logic [alu_pkg::DATA_W-1:0] ALU_DATA;
  logic                      WB_VALID;
  logic                      WB_READY;
  logic [DST_W-1:0]          WB_DST;
  logic [alu_pkg::DATA_W-1:0] WB_LO;
  logic [alu_pkg::DATA_W-1:0] WB_HI;
  logic                      WB_WIDE;
  logic                      BUSY;
  logic                      ERR;

  modport master (
    output ISSUE, ISSUE_MUL, ISSUE_DST, ALU_VLD, ALU_DATA, WB_READY,
    input  ISSUE_OK, WB_VALID, WB_DST, WB_LO, WB_HI, WB_WIDE, BUSY, ERR
  );

  modport slave (
    input  ISSUE, ISSUE_MUL, ISSUE_DST, ALU_VLD, ALU_DATA, WB_READY,
    output ISSUE_OK, WB_VALID, WB_DST, WB_LO, WB_HI, WB_WIDE, BUSY, ERR
  );

endinterface

// File: rtl/alu_result_fifo.sv
// DEPTH-deep synchronous FIFO of write-back entries with a registered head
// that reads as all-zero while the FIFO is empty.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  wb_entry_t        push_data,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count_nxt_c
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count;
  logic             pop_ok_c;
  logic             push_ok_c;
  wb_entry_t        head_nxt_c;

  // A pop frees its slot in the same cycle, so a full FIFO can still accept.
  assign pop_ok_c   = pop & ~empty;
  assign push_ok_c  = push & (~full | pop_ok_c);
  assign rd_ptr_inc = PTR_W'(rd_ptr + 1'b1);

  always_comb begin
    count_nxt_c = count;
    if (push_ok_c && !pop_ok_c) begin
      count_nxt_c = CNT_W'(count + 1'b1);
    end else if (pop_ok_c && !push_ok_c) begin
      count_nxt_c = CNT_W'(count - 1'b1);
    end
  end

  // Next head: the new entry when it lands in an empty slot, else the next stored one.
  always_comb begin
    head_nxt_c = head;
    if (count_nxt_c == '0) begin
      head_nxt_c = '0;
    end else if (pop_ok_c) begin
      head_nxt_c = (count == CNT_W'(1)) ? push_data : mem[rd_ptr_inc];
    end else if (empty) begin
      head_nxt_c = push_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      head   <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop_ok_c)  rd_ptr <= rd_ptr_inc;
      count <= count_nxt_c;
      empty <= (count_nxt_c == '0);
      full  <= (count_nxt_c == DEPTH_C);
      head  <= head_nxt_c;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_result_collector.sv
// Collects ALU result beats (merging two-beat multiplies) into tagged entries,
// buffers them for register-file write-back and issues credit to the issue logic.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DST_W = ENTRY_DST_W
) (
  input logic                   CLK,
  input logic                   RST,
  alu_result_collector_if.slave bus
);

  localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  coll_state_e       state_q;
  coll_state_e       state_d;
  logic [DST_W-1:0]  dst_q;
  logic [DATA_W-1:0] lo_q;
  logic              err_q;
  logic              issue_ok_q;
  logic              busy_q;

  logic              cap_dst_c;
  logic              cap_lo_c;
  logic              push_c;
  logic              pop_c;
  logic              drop_c;
  logic              err_set_c;
  wb_entry_t         push_data_c;

  wb_entry_t         head;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  count_nxt_c;

  assign pop_c  = bus.WB_READY & ~fifo_empty;
  assign drop_c = push_c & fifo_full & ~pop_c;

  // Collector next-state, capture strobes, push and protocol-error detection.
  always_comb begin
    state_d     = state_q;
    cap_dst_c   = 1'b0;
    cap_lo_c    = 1'b0;
    push_c      = 1'b0;
    push_data_c = '0;
    err_set_c   = 1'b0;

    if (bus.ISSUE && !issue_ok_q) err_set_c = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.ALU_VLD) err_set_c = 1'b1;
        if (bus.ISSUE && issue_ok_q) begin
          cap_dst_c = 1'b1;
          state_d   = bus.ISSUE_MUL ? WAIT_LO : WAIT_SINGLE;
        end
      end
      WAIT_SINGLE: begin
        if (bus.ALU_VLD) begin
          push_c      = 1'b1;
          push_data_c = mk_entry(ENTRY_DST_W'(dst_q), bus.ALU_DATA, '0, 1'b0);
          state_d     = IDLE;
        end
      end
      WAIT_LO: begin
        if (bus.ALU_VLD) begin
          cap_lo_c = 1'b1;
          state_d  = WAIT_HI;
        end
      end
      WAIT_HI: begin
        // The high beat must follow the low beat directly; a gap abandons the op.
        if (bus.ALU_VLD) begin
          push_c      = 1'b1;
          push_data_c = mk_entry(ENTRY_DST_W'(dst_q), lo_q, bus.ALU_DATA, 1'b1);
        end else begin
          err_set_c = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (drop_c) err_set_c = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Credit and busy are registered from next-cycle state so they match the FIFO view.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dst_q      <= '0;
      lo_q       <= '0;
      err_q      <= 1'b0;
      issue_ok_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      if (cap_dst_c) dst_q <= bus.ISSUE_DST;
      if (cap_lo_c)  lo_q  <= bus.ALU_DATA;
      if (err_set_c) err_q <= 1'b1;
      issue_ok_q <= (state_d == IDLE) && (count_nxt_c != DEPTH_C);
      busy_q     <= (state_d != IDLE) || (count_nxt_c != '0);
    end
  end

  alu_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .push        (push_c),
    .push_data   (push_data_c),
    .pop         (bus.WB_READY),
    .head        (head),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .count_nxt_c (count_nxt_c)
  );

  assign bus.ISSUE_OK = issue_ok_q;
  assign bus.BUSY     = busy_q;
  assign bus.ERR      = err_q;
  assign bus.WB_VALID = ~fifo_empty;
  assign bus.WB_DST   = DST_W'(head.dst);
  assign bus.WB_LO    = head.lo;
  assign bus.WB_HI    = head.hi;
  assign bus.WB_WIDE  = head.wide;

endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench for alu_result_collector: a transaction-level model
// compared every cycle, plus directed literal expectations.
module tb_alu_result_collector;

  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  alu_result_collector_if #(.DST_W(5)) bus ();

  alu_result_collector #(.DEPTH(DEPTH), .DST_W(5)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        wide;
  } exp_t;

  // Model: queue of completed results plus the one op in flight.
  exp_t        mq[$];
  int          beats_left = 0;
  logic        is_mul     = 1'b0;
  logic [4:0]  m_dst      = '0;
  logic [31:0] m_lo       = '0;
  logic        m_err      = 1'b0;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    bit   ok;
    bit   have_new;
    exp_t e;
    if (RST) begin
      mq.delete();
      beats_left = 0;
      is_mul     = 1'b0;
      m_err      = 1'b0;
    end else begin
      ok       = (beats_left == 0) && (mq.size() < DEPTH);
      have_new = 1'b0;
      e        = '{dst: 5'd0, lo: 32'd0, hi: 32'd0, wide: 1'b0};
      if (beats_left != 0) begin
        if (bus.ALU_VLD) begin
          beats_left--;
          if (beats_left != 0) begin
            m_lo = bus.ALU_DATA;
          end else begin
            have_new = 1'b1;
            e.dst    = m_dst;
            e.wide   = is_mul;
            e.lo     = is_mul ? m_lo : bus.ALU_DATA;
            e.hi     = is_mul ? bus.ALU_DATA : 32'd0;
          end
        end else if (is_mul && beats_left == 1) begin
          m_err      = 1'b1;
          beats_left = 0;
        end
      end else if (bus.ALU_VLD) begin
        m_err = 1'b1;
      end
      if (bus.ISSUE) begin
        if (ok) begin
          beats_left = bus.ISSUE_MUL ? 2 : 1;
          is_mul     = bus.ISSUE_MUL;
          m_dst      = bus.ISSUE_DST;
        end else begin
          m_err = 1'b1;
        end
      end
      if (mq.size() != 0 && bus.WB_READY) void'(mq.pop_front());
      if (have_new) begin
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_err = 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    exp_t h;
    if (chk_en) begin
      h = '{dst: 5'd0, lo: 32'd0, hi: 32'd0, wide: 1'b0};
      if (mq.size() != 0) h = mq[0];
      check("cyc_wb_valid", 64'(bus.WB_VALID), 64'(mq.size() != 0));
      check("cyc_wb_dst",   64'(bus.WB_DST),   64'(h.dst));
      check("cyc_wb_lo",    64'(bus.WB_LO),    64'(h.lo));
      check("cyc_wb_hi",    64'(bus.WB_HI),    64'(h.hi));
      check("cyc_wb_wide",  64'(bus.WB_WIDE),  64'(h.wide));
      check("cyc_issue_ok", 64'(bus.ISSUE_OK), 64'((beats_left == 0) && (mq.size() < DEPTH)));
      check("cyc_busy",     64'(bus.BUSY),     64'((beats_left != 0) || (mq.size() != 0)));
      check("cyc_err",      64'(bus.ERR),      64'(m_err));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick(input logic iss, input logic mul, input logic [4:0] dst,
                      input logic vld, input logic [31:0] data);
    bus.ISSUE     = iss;
    bus.ISSUE_MUL = mul;
    bus.ISSUE_DST = dst;
    bus.ALU_VLD   = vld;
    bus.ALU_DATA  = data;
    step();
    bus.ISSUE     = 1'b0;
    bus.ISSUE_MUL = 1'b0;
    bus.ISSUE_DST = '0;
    bus.ALU_VLD   = 1'b0;
    bus.ALU_DATA  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 5'd0, 1'b0, 32'd0);
  endtask

  // Single-beat op with a two-cycle ALU latency.
  task automatic single(input logic [4:0] dst, input logic [31:0] data);
    tick(1'b1, 1'b0, dst, 1'b0, 32'd0);
    idle(1);
    tick(1'b0, 1'b0, 5'd0, 1'b1, data);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin
    RST           = 1'b1;
    bus.ISSUE     = 1'b0;
    bus.ISSUE_MUL = 1'b0;
    bus.ISSUE_DST = '0;
    bus.ALU_VLD   = 1'b0;
    bus.ALU_DATA  = '0;
    bus.WB_READY  = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    RST = 1'b0;
    check("rst_wb_valid", 64'(bus.WB_VALID), 64'd0);
    check("rst_busy",     64'(bus.BUSY),     64'd0);
    check("rst_issue_ok", 64'(bus.ISSUE_OK), 64'd1);
    check("rst_err",      64'(bus.ERR),      64'd0);
    check("rst_wb_lo",    64'(bus.WB_LO),    64'd0);

    // Add op: result visible three cycles after issue.
    tick(1'b1, 1'b0, 5'd3, 1'b0, 32'd0);
    check("add_issue_ok_busy", 64'(bus.ISSUE_OK), 64'd0);
    check("add_busy",          64'(bus.BUSY),     64'd1);
    idle(1);
    check("add_not_yet", 64'(bus.WB_VALID), 64'd0);
    tick(1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_0007);
    check("add_valid", 64'(bus.WB_VALID), 64'd1);
    check("add_dst",   64'(bus.WB_DST),   64'd3);
    check("add_lo",    64'(bus.WB_LO),    64'd7);
    check("add_hi",    64'(bus.WB_HI),    64'd0);
    check("add_wide",  64'(bus.WB_WIDE),  64'd0);
    bus.WB_READY = 1'b1;
    idle(1);
    check("add_popped", 64'(bus.WB_VALID), 64'd0);
    check("add_idle",   64'(bus.BUSY),     64'd0);
    bus.WB_READY = 1'b0;

    // Multiply: two beats merge into one wide entry.
    tick(1'b1, 1'b1, 5'd9, 1'b0, 32'd0);
    idle(1);
    tick(1'b0, 1'b0, 5'd0, 1'b1, 32'hFFFF_FFFE);
    check("mul_between_beats", 64'(bus.WB_VALID), 64'd0);
    tick(1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_0001);
    check("mul_valid", 64'(bus.WB_VALID), 64'd1);
    check("mul_dst",   64'(bus.WB_DST),   64'd9);
    check("mul_lo",    64'(bus.WB_LO),    64'hFFFF_FFFE);
    check("mul_hi",    64'(bus.WB_HI),    64'd1);
    check("mul_wide",  64'(bus.WB_WIDE),  64'd1);
    bus.WB_READY = 1'b1;
    idle(1);
    bus.WB_READY = 1'b0;

    // Backpressure: fill the FIFO, credit drops, one pop restores it.
    for (int i = 1; i <= 4; i++) single(5'(i), 32'h100 + 32'(i));
    check("full_issue_ok", 64'(bus.ISSUE_OK), 64'd0);
    check("full_head_dst", 64'(bus.WB_DST),   64'd1);
    bus.WB_READY = 1'b1;
    idle(1);
    check("pop_issue_ok", 64'(bus.ISSUE_OK), 64'd1);
    for (int i = 2; i <= 4; i++) begin
      check("drain_order", 64'(bus.WB_DST), 64'(i));
      idle(1);
    end
    check("drain_empty", 64'(bus.WB_VALID), 64'd0);
    bus.WB_READY = 1'b0;

    // Simultaneous push and pop at count DEPTH-1.
    single(5'd10, 32'hA);
    single(5'd11, 32'hB);
    single(5'd12, 32'hC);
    tick(1'b1, 1'b0, 5'd13, 1'b0, 32'd0);
    idle(1);
    bus.WB_READY = 1'b1;
    tick(1'b0, 1'b0, 5'd0, 1'b1, 32'hD);
    check("pp_err",      64'(bus.ERR),      64'd0);
    check("pp_issue_ok", 64'(bus.ISSUE_OK), 64'd1);
    for (int i = 11; i <= 13; i++) begin
      check("pp_order", 64'(bus.WB_DST), 64'(i));
      idle(1);
    end
    check("pp_empty", 64'(bus.WB_VALID), 64'd0);
    bus.WB_READY = 1'b0;

    // Errors: stray beat in IDLE, gap in a multiply, issue without credit.
    tick(1'b0, 1'b0, 5'd0, 1'b1, 32'h55);
    check("stray_err",   64'(bus.ERR),      64'd1);
    check("stray_nopush", 64'(bus.WB_VALID), 64'd0);
    do_reset();
    check("err_cleared", 64'(bus.ERR), 64'd0);
    tick(1'b1, 1'b1, 5'd5, 1'b0, 32'd0);
    idle(1);
    tick(1'b0, 1'b0, 5'd0, 1'b1, 32'h1234);
    idle(1);
    check("gap_err",      64'(bus.ERR),      64'd1);
    check("gap_idle",     64'(bus.ISSUE_OK), 64'd1);
    check("gap_nopush",   64'(bus.WB_VALID), 64'd0);
    check("gap_not_busy", 64'(bus.BUSY),     64'd0);
    do_reset();
    tick(1'b1, 1'b0, 5'd1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 5'd2, 1'b0, 32'd0);
    check("nocredit_err", 64'(bus.ERR), 64'd1);
    tick(1'b0, 1'b0, 5'd0, 1'b1, 32'h77);
    check("nocredit_dst", 64'(bus.WB_DST), 64'd1);
    do_reset();

    // Reset in WAIT_HI with two entries queued.
    single(5'd20, 32'h1);
    single(5'd21, 32'h2);
    tick(1'b1, 1'b1, 5'd22, 1'b0, 32'd0);
    idle(1);
    tick(1'b0, 1'b0, 5'd0, 1'b1, 32'hAAAA);
    check("pre_rst_busy", 64'(bus.BUSY), 64'd1);
    do_reset();
    check("mid_rst_valid",    64'(bus.WB_VALID), 64'd0);
    check("mid_rst_busy",     64'(bus.BUSY),     64'd0);
    check("mid_rst_issue_ok", 64'(bus.ISSUE_OK), 64'd1);
    check("mid_rst_err",      64'(bus.ERR),      64'd0);
    check("mid_rst_dst",      64'(bus.WB_DST),   64'd0);
    single(5'd7, 32'h99);
    check("post_rst_lo", 64'(bus.WB_LO), 64'h99);
    bus.WB_READY = 1'b1;
    idle(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
